// File: rtl/coax_bit_timer_v2.sv
// Bit-period timer with programmable period, mid/end strobes and a completed-bit counter.
// Optional resync realignment is compiled in with `define COAX_BIT_TIMER_RESYNC_EN.
module coax_bit_timer_v2 #(
  parameter int unsigned MAX_CLOCKS_PER_BIT     = 16,
  parameter int unsigned DEFAULT_CLOCKS_PER_BIT = 8,
  parameter int unsigned COUNT_WIDTH            = 8,
  localparam int unsigned PW = $clog2(MAX_CLOCKS_PER_BIT + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable_i,
  input  logic [PW-1:0]          clocks_per_bit_i,
  input  logic                   resync_i,
  output logic                   active_o,
  output logic                   first_half_o,
  output logic                   second_half_o,
  output logic                   mid_strobe_o,
  output logic                   end_strobe_o,
  output logic [COUNT_WIDTH-1:0] bit_count_o
);

  localparam int unsigned DefClamped =
      (DEFAULT_CLOCKS_PER_BIT < 4) ? 4 :
      (DEFAULT_CLOCKS_PER_BIT > MAX_CLOCKS_PER_BIT) ? MAX_CLOCKS_PER_BIT : DEFAULT_CLOCKS_PER_BIT;
  localparam logic [PW-1:0] DefaultPeriod = PW'(DefClamped);

  typedef enum logic {StIdle, StRun} state_e;

  function automatic logic [PW-1:0] clamp_period(input logic [PW-1:0] x);
    if (x < PW'(4)) begin
      return PW'(4);
    end else if (x > PW'(MAX_CLOCKS_PER_BIT)) begin
      return PW'(MAX_CLOCKS_PER_BIT);
    end
    return x;
  endfunction

  state_e                 state_q, state_d;
  logic [PW-1:0]          counter_q, counter_d;
  logic [PW-1:0]          period_q, period_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   active_q, first_half_q, second_half_q, mid_q, end_q;
  logic                   active_d, first_half_d, second_half_d, mid_d, end_d;
  logic [PW-1:0]          next_period;
  logic [PW-1:0]          half_d;
  logic                   last_cycle;

`ifndef COAX_BIT_TIMER_RESYNC_EN
  logic unused_resync;
  assign unused_resync = resync_i;
`endif

  always_comb begin
    state_d     = state_q;
    counter_d   = counter_q;
    period_d    = period_q;
    count_d     = count_q;
    next_period = clamp_period(clocks_per_bit_i);
    last_cycle  = (counter_q == period_q - PW'(1));

    unique case (state_q)
      StIdle: begin
        counter_d = '0;
        if (enable_i) begin
          state_d  = StRun;
          period_d = next_period;
          count_d  = '0;
        end
      end
      StRun: begin
        if (!enable_i) begin
          state_d   = StIdle;
          counter_d = '0;
`ifdef COAX_BIT_TIMER_RESYNC_EN
        end else if (resync_i) begin
          // A resync on the final cycle still closes the bit; the new phase uses the new period.
          if (last_cycle) begin
            period_d = next_period;
            count_d  = count_q + COUNT_WIDTH'(1);
          end
          counter_d = period_d >> 1;
`endif
        end else if (last_cycle) begin
          counter_d = '0;
          period_d  = next_period;
          count_d   = count_q + COUNT_WIDTH'(1);
        end else begin
          counter_d = counter_q + PW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered copies of the decode of the next register values.
    half_d        = period_d >> 1;
    active_d      = (state_d == StRun);
    first_half_d  = active_d && (counter_d < half_d);
    second_half_d = active_d && (counter_d >= half_d);
    mid_d         = active_d && (counter_d == half_d - PW'(1));
    end_d         = active_d && (counter_d == period_d - PW'(1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      counter_q     <= '0;
      period_q      <= DefaultPeriod;
      count_q       <= '0;
      active_q      <= 1'b0;
      first_half_q  <= 1'b0;
      second_half_q <= 1'b0;
      mid_q         <= 1'b0;
      end_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      counter_q     <= counter_d;
      period_q      <= period_d;
      count_q       <= count_d;
      active_q      <= active_d;
      first_half_q  <= first_half_d;
      second_half_q <= second_half_d;
      mid_q         <= mid_d;
      end_q         <= end_d;
    end
  end

  assign active_o      = active_q;
  assign first_half_o  = first_half_q;
  assign second_half_o = second_half_q;
  assign mid_strobe_o  = mid_q;
  assign end_strobe_o  = end_q;
  assign bit_count_o   = count_q;

endmodule

// File: tb/tb_coax_bit_timer_v2.sv
// Scoreboard bench for coax_bit_timer_v2: expected strobe events are queued by the stimulus
// and popped by an independent monitor; level outputs are checked directly.
module tb_coax_bit_timer_v2;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [4:0] cpb;
  logic       resync;
  logic       active, first_half, second_half, mid_strobe, end_strobe;
  logic [7:0] bit_count;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int kind;  // 0 = mid strobe, 1 = end strobe
    int cyc;
    int bc;
  } ev_t;
  ev_t q[$];

  coax_bit_timer_v2 #(
    .MAX_CLOCKS_PER_BIT    (16),
    .DEFAULT_CLOCKS_PER_BIT(8),
    .COUNT_WIDTH           (8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .enable_i        (enable),
    .clocks_per_bit_i(cpb),
    .resync_i        (resync),
    .active_o        (active),
    .first_half_o    (first_half),
    .second_half_o   (second_half),
    .mid_strobe_o    (mid_strobe),
    .end_strobe_o    (end_strobe),
    .bit_count_o     (bit_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int c, input int bc);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.bc   = bc;
    q.push_back(e);
  endtask

  task automatic push_bit(input int c0, input int p, input int h, input int bc);
    push(0, c0 + h - 1, bc);
    push(1, c0 + p - 1, bc);
  endtask

  // Monitor: every strobe must match the head of the queue; overdue entries are misses.
  always @(negedge clk) begin
    if (!reset) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        n_cmp++;
        n_err++;
        $display("FAIL strobe_missed: got none, expected kind=%0d at cyc %0d", q[0].kind,
                 q[0].cyc);
        void'(q.pop_front());
      end
      if (mid_strobe || end_strobe) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL strobe_unexpected: got mid=%0b end=%0b at cyc %0d, expected none",
                   mid_strobe, end_strobe, cyc);
        end else begin
          if (q[0].cyc != cyc || q[0].kind != int'(end_strobe) || mid_strobe == end_strobe ||
              q[0].bc != int'(bit_count)) begin
            n_err++;
            $display("FAIL strobe: got kind=%0d cyc=%0d bc=%0d, expected kind=%0d cyc=%0d bc=%0d",
                     int'(end_strobe), cyc, bit_count, q[0].kind, q[0].cyc, q[0].bc);
          end
          if (q[0].cyc <= cyc) void'(q.pop_front());
        end
      end
    end
  end

  // Enable, run nbits full bits, then disable; p and h are hand-computed for the request.
  task automatic run_test(input string name, input int req, input int p, input int h,
                          input int nbits);
    int c0, fh, sh;
    enable = 1'b1;
    cpb    = 5'(req);
    c0     = cyc + 1;
    for (int b = 0; b < nbits; b++) push_bit(c0 + b * p, p, h, b);
    tick(1);
    check({name, "_active"}, int'(active), 1);
    check({name, "_first_half_at_start"}, int'(first_half), 1);
    fh = 0;
    sh = 0;
    for (int i = 0; i < p * nbits; i++) begin
      if (i % p == 0) check({name, "_bit_count"}, int'(bit_count), i / p);
      fh += int'(first_half);
      sh += int'(second_half);
      tick(1);
    end
    check({name, "_bit_count_end"}, int'(bit_count), nbits);
    check({name, "_first_half_cycles"}, fh, h * nbits);
    check({name, "_second_half_cycles"}, sh, (p - h) * nbits);
    enable = 1'b0;
    tick(1);
    check({name, "_idle_active"}, int'(active), 0);
    check({name, "_idle_bit_count"}, int'(bit_count), nbits);
    tick(1);
  endtask

  initial begin
    int c0;
    reset  = 1'b1;
    enable = 1'b0;
    cpb    = 5'd8;
    resync = 1'b0;
    #2;
    check("reset_active", int'(active), 0);
    check("reset_halves", int'(first_half | second_half), 0);
    check("reset_strobes", int'(mid_strobe | end_strobe), 0);
    check("reset_bit_count", int'(bit_count), 0);
    tick(2);
    reset = 1'b0;
    tick(2);
    check("idle_active", int'(active), 0);

    run_test("basic", 8, 8, 4, 3);

    // Period change 8 -> 12 at counter 2 of the first bit.
    enable = 1'b1;
    cpb    = 5'd8;
    c0     = cyc + 1;
    push_bit(c0, 8, 4, 0);
    push_bit(c0 + 8, 12, 6, 1);
    tick(3);
    cpb = 5'd12;
    tick(18);
    check("period_change_bit_count", int'(bit_count), 2);
    enable = 1'b0;
    tick(2);

    run_test("clamp_lo", 2, 4, 2, 2);
    run_test("clamp_hi", 20, 16, 8, 1);
    run_test("odd", 9, 9, 4, 1);

    // Resync at counter 1.
    enable = 1'b1;
    cpb    = 5'd8;
    c0     = cyc + 1;
`ifdef COAX_BIT_TIMER_RESYNC_EN
    push(1, c0 + 5, 0);
    push_bit(c0 + 6, 8, 4, 1);
`else
    push_bit(c0, 8, 4, 0);
    push_bit(c0 + 8, 8, 4, 1);
`endif
    tick(2);
    resync = 1'b1;
    tick(1);
    resync = 1'b0;
`ifdef COAX_BIT_TIMER_RESYNC_EN
    check("resync_second_half", int'(second_half), 1);
    tick(12);
`else
    check("resync_second_half", int'(second_half), 0);
    tick(14);
`endif
    check("resync_bit_count", int'(bit_count), 2);
    enable = 1'b0;
    tick(2);

    // Resync coincident with the end of the bit.
    enable = 1'b1;
    cpb    = 5'd8;
    c0     = cyc + 1;
    push_bit(c0, 8, 4, 0);
`ifdef COAX_BIT_TIMER_RESYNC_EN
    push(1, c0 + 11, 1);
`else
    push(0, c0 + 11, 1);
`endif
    tick(8);
    resync = 1'b1;
    tick(1);
    resync = 1'b0;
    check("resync_end_bit_count", int'(bit_count), 1);
`ifdef COAX_BIT_TIMER_RESYNC_EN
    check("resync_end_second_half", int'(second_half), 1);
    tick(4);
    check("resync_end_bit_count2", int'(bit_count), 2);
`else
    check("resync_end_second_half", int'(second_half), 0);
    tick(4);
    check("resync_end_bit_count2", int'(bit_count), 1);
`endif
    enable = 1'b0;
    tick(2);

    // Enable drop at counter 5 of the second bit.
    enable = 1'b1;
    cpb    = 5'd8;
    c0     = cyc + 1;
    push_bit(c0, 8, 4, 0);
    push(0, c0 + 11, 1);
    tick(14);
    enable = 1'b0;
    tick(1);
    check("drop_active", int'(active), 0);
    check("drop_halves", int'(first_half | second_half), 0);
    check("drop_end_strobe", int'(end_strobe), 0);
    check("drop_bit_count_holds", int'(bit_count), 1);
    tick(1);
    run_test("restart", 8, 8, 4, 1);

    // Asynchronous reset at counter 3 of the second bit.
    enable = 1'b1;
    cpb    = 5'd8;
    c0     = cyc + 1;
    push_bit(c0, 8, 4, 0);
    tick(12);
    reset = 1'b1;
    #1;
    check("async_reset_active", int'(active), 0);
    check("async_reset_mid", int'(mid_strobe), 0);
    check("async_reset_first_half", int'(first_half), 0);
    check("async_reset_bit_count", int'(bit_count), 0);
    tick(2);
    reset = 1'b0;
    #1;
    check("post_reset_active", int'(active), 0);
    tick(1);
    check("post_reset_run", int'(active), 1);
    check("post_reset_first_half", int'(first_half), 1);
    enable = 1'b0;
    tick(4);

    check("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/coax_bit_timer_v2.md
# coax_bit_timer_v2

Parametrised bit-period timer for the coax TX/RX datapaths. It has a runtime-programmable period, an enable gate, mid-bit and end-of-bit strobes, and a completed-bit counter. It also accepts an optional resync pulse that realigns the bit phase to an observed mid-bit transition. It sits between the serializer or deserializer control FSM and the line interface, and replaces the fixed-period timer on paths that must track a drifting received signal.

## Interface
- MAX_CLOCKS_PER_BIT, 16: largest supported bit period in clk cycles; must be ≥ 4.
- DEFAULT_CLOCKS_PER_BIT, 8: period loaded at reset; clamped to the range 4..MAX_CLOCKS_PER_BIT.
- COUNT_WIDTH, 8: width of bit_count.
- Derived PW = $clog2(MAX_CLOCKS_PER_BIT+1): width of the period and counter fields.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  run request. Low forces IDLE.
- clocks_per_bit  in  PW  requested period. Sampled only at bit boundaries.
- resync  in  1  single-cycle pulse meaning "the line transition is now at mid-bit".
- active  out  1  high in RUN.
- first_half  out  1  counter < P/2, in RUN only.
- second_half  out  1  counter ≥ P/2, in RUN only.
- mid_strobe  out  1  last cycle of the first half.
- end_strobe  out  1  last cycle of the bit.
- bit_count  out  COUNT_WIDTH  completed bits since the last enable rise; wraps modulo 2^COUNT_WIDTH.

## Operation
- Registers:
  - state: IDLE or RUN.
  - counter: PW bits.
  - P: active period, PW bits.
  - bit_count.
- Clamp function: clamp(x) = 4 if x < 4; MAX_CLOCKS_PER_BIT if x > MAX_CLOCKS_PER_BIT; otherwise x. H = P >> 1, using floor division, so odd P gives a shorter first half.
- IDLE:
  - counter = 0.
  - All outputs are 0 except bit_count, which holds its value.
  - resync is ignored.
  - When enable = 1, go to RUN, with counter ← 0, P ← clamp(clocks_per_bit), bit_count ← 0.
- RUN, evaluated each cycle in the following priority order:
  1. enable = 0: go to IDLE, counter ← 0. bit_count holds.
  2. resync = 1 (feature compiled in): counter ← H_next. If counter == P−1 in this same cycle, it is also a bit boundary, so bit_count increments and P ← clamp(clocks_per_bit). H_next is computed from the P in effect after this cycle.
  3. counter == P−1: counter ← 0, P ← clamp(clocks_per_bit), bit_count ← bit_count + 1.
  4. Otherwise: counter ← counter + 1.
- Output decode:
  - mid_strobe = RUN && counter == H−1.
  - end_strobe = RUN && counter == P−1.
  - Both strobes assert exactly once per uninterrupted bit.
- A change to clocks_per_bit in mid-bit never alters the current bit. It takes effect at the next boundary.

## Timing
- Reset values: state = IDLE, counter = 0, P = clamp(DEFAULT_CLOCKS_PER_BIT), bit_count = 0. All 1-bit outputs are 0.
- All outputs are decoded from registers only; there is no combinational path from any input to any output.
- enable rise at edge n: active and first_half are high from cycle n+1 with counter = 0.
- enable fall: outputs drop to 0 on the next cycle. A partial bit is not counted.
- resync sampled at edge n: second_half = 1 at cycle n+1, with end_strobe H cycles of counting later, i.e. P−H cycles after n.
- Bit length with no resync: exactly P cycles from counter = 0 to the end_strobe cycle inclusive.
- Reset asserted in mid-bit clears everything immediately (asynchronous). After release the block restarts from IDLE. enable must be seen high on a clock edge before RUN is entered.

## Configuration
- COAX_BIT_TIMER_RESYNC_EN defined: resync behaves as described in priority step 2.
- Not defined: the resync port remains present but is ignored, and the timer is free-running. All other behaviour is identical.

## Test plan
- Basic period: P = 8, enable held high → first_half for 4 cycles, mid_strobe at counter = 3, end_strobe at counter = 7, bit_count = 1, 2, 3 after 8, 16, 24 cycles.
- Period change: clocks_per_bit changes 8 → 12 at counter = 2 → the current bit ends after 8 cycles, the next bit lasts 12 cycles, and mid_strobe is at counter = 5.
- Clamping: clocks_per_bit = 2 → 4-cycle bits. clocks_per_bit = 20 with MAX = 16 → 16-cycle bits. Odd P = 9 → first_half 4 cycles, second_half 5 cycles.
- Resync (macro defined): P = 8, resync at counter = 1 → counter = 4 next cycle, end_strobe 4 cycles later, no extra bit counted. The same stimulus without the macro → no phase shift.
- Resync coincident with end: resync at counter = 7 → bit_count increments and the next counter is 4.
- Enable and reset: enable drops at counter = 5 → outputs 0 next cycle and bit_count holds. Re-raising enable restarts the bit at 0 with bit_count = 0. Asynchronous reset at counter = 3 → all outputs 0 immediately, and P returns to DEFAULT.
